exc_controller: RTL

EXC_CONTROLLER -- requirements
Module: exc_controller

---
 rtl/exc_controller.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/exc_controller.sv
// Exception / interrupt request controller.
// Arbitrates synchronous exceptions from the ID stage against edge-triggered
// external interrupts. It presents one request and cause to the core
// controller, and tracks whether an interrupt handler is active.
// Optional build macro IRQ_SYNC_EN: when defined, irq_i is passed through a
// two-flop synchronizer before edge detection.
module exc_controller (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] irq_i,
    input  logic        irq_enable_i,
    input  logic        is_decoding_i,
    input  logic        illegal_insn_i,
    input  logic        ebrk_insn_i,
    input  logic        ecall_insn_i,
    input  logic        eret_insn_i,
    input  logic        exc_ack_i,
    output logic        exc_req_o,
    output logic [5:0]  exc_cause_o,
    output logic        save_cause_o,
    output logic        in_handler_o
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_IRQ_REQ = 2'd1;
    localparam logic [1:0] ST_HANDLER = 2'd2;

    localparam logic [5:0] CAUSE_ILLEGAL = 6'h02;
    localparam logic [5:0] CAUSE_EBREAK  = 6'h03;
    localparam logic [5:0] CAUSE_ECALL   = 6'h0B;

    logic [1:0]  state_q, state_d;
    logic [4:0]  irq_id_q, irq_id_d;
    logic [31:0] irq_pending_q, irq_pending_d;
    logic [31:0] irq_prev_q, irq_prev_d;
    logic [31:0] irq_s;
    logic [31:0] irq_rise;
    logic [31:0] irq_clr;
    logic [4:0]  irq_win_id;
    logic        irq_eligible;
    logic        sync_req;
    logic [5:0]  sync_cause;

`ifdef IRQ_SYNC_EN
    logic [31:0] sync1_q, sync1_d;
    logic [31:0] sync2_q, sync2_d;

    // Two-stage synchronizer for the asynchronous interrupt lines.
    always_comb begin
        sync1_d = irq_i;
        sync2_d = sync1_q;
    end

    // Synchronizer flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign irq_s = sync2_q;
`else
    assign irq_s = irq_i;
`endif

    // Synchronous exception request and its prioritised cause code.
    always_comb begin
        // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
        sync_cause = CAUSE_ECALL;
        if (ebrk_insn_i)    sync_cause = CAUSE_EBREAK;
        if (illegal_insn_i) sync_cause = CAUSE_ILLEGAL;
        sync_req = is_decoding_i & (illegal_insn_i | ebrk_insn_i | ecall_insn_i);
    end

    // Lowest-index pending interrupt wins; scanning downwards lets the lowest set bit overwrite.
    always_comb begin
        irq_win_id = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (irq_pending_q[i]) irq_win_id = 5'(i);
        end
        irq_eligible = (irq_pending_q != '0) && irq_enable_i && (state_q == ST_IDLE);
    end

    // Interrupt FSM plus pending-bit bookkeeping; a new edge beats a same-cycle clear.
    always_comb begin
        state_d    = state_q;
        irq_id_d   = irq_id_q;
        irq_clr    = '0;
        irq_prev_d = irq_s;
        irq_rise   = irq_s & ~irq_prev_q;

        case (state_q)
            ST_IDLE: begin
                if (irq_eligible) begin
                    state_d  = ST_IRQ_REQ;
                    irq_id_d = irq_win_id;
                end
            end
            ST_IRQ_REQ: begin
                // A synchronous exception takes the ack; the interrupt waits behind it.
                if (exc_ack_i && !sync_req) begin
                    state_d           = ST_HANDLER;
                    irq_clr[irq_id_q] = 1'b1;
                end
            end
            ST_HANDLER: begin
                if (is_decoding_i && eret_insn_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        irq_pending_d = (irq_pending_q & ~irq_clr) | irq_rise;
    end

    // Request, cause and strobe outputs; synchronous exceptions override interrupts.
    always_comb begin
        exc_req_o   = sync_req | (state_q == ST_IRQ_REQ);
        exc_cause_o = 6'h00;
        if (state_q == ST_IRQ_REQ) exc_cause_o = {1'b1, irq_id_q};
        if (sync_req)              exc_cause_o = sync_cause;
        save_cause_o = exc_req_o & exc_ack_i;
        in_handler_o = (state_q == ST_HANDLER);
    end

    // State registers; reset discards any pending or active interrupt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            irq_id_q      <= '0;
            irq_pending_q <= '0;
            irq_prev_q    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q       <= state_d;
            irq_id_q      <= irq_id_d;
            irq_pending_q <= irq_pending_d;
            irq_prev_q    <= irq_prev_d;
        end
    end

endmodule
